// File: rtl/dac_serial_writer.sv
// Serial writer for the front-end DAC daisy chain: shifts a word MSB-first under a divided SCLK,
// optionally repeats the frame while driving compare/clear strobes for the chain error detector.
module dac_serial_writer #(
  parameter int WIDTH   = 24,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             verify,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             dac_sclk,
  output logic             dac_sync_n,
  output logic             dac_din,
  input  logic             dac_dout,
  output logic             cmp_en,
  output logic             cmp_clr,
  output logic [2:0]       fsm_state
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] CD_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_FALL = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    cnt, cnt_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] sreg, sreg_n, word_q;
  logic             verify_q, frame2, frame2_n;
  logic             end_tx, accept, repeat_frame, shift_step;
  logic             busy_d, done_d, sclk_d, sync_n_d, din_d, cmp_en_d, cmp_clr_d;

  assign fsm_state = state;

  // State register: cnt is the cycle count within SETUP/HOLD/GAP and the bit phase within SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    end_tx  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_SETUP;
        cnt_n   = '0;
      end
      S_SETUP: if (cnt == CD_LAST) begin
        state_n = S_SHIFT;
        cnt_n   = '0;
        bit_n   = BIT_TOP;
      end else cnt_n = cnt + 1'b1;
      S_SHIFT: if (cnt == PH_LAST) begin
        cnt_n = '0;
        if (bit_cnt == '0) state_n = S_HOLD;
        else bit_n = bit_cnt - 1'b1;
      end else cnt_n = cnt + 1'b1;
      S_HOLD: if (cnt == CD_LAST) begin
        state_n = S_GAP;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      S_GAP: if (cnt == PH_LAST) begin
        cnt_n = '0;
        if (verify_q && !frame2) state_n = S_SETUP;
        else begin
          state_n = S_IDLE;
          end_tx  = 1'b1;
        end
      end else cnt_n = cnt + 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  assign accept       = (state == S_IDLE) && start;
  assign repeat_frame = (state == S_GAP) && (cnt == PH_LAST) && verify_q && !frame2;
  assign shift_step   = (state == S_SHIFT) && (cnt == PH_LAST) && (bit_cnt != '0);

  always_comb begin
    frame2_n = frame2;
    sreg_n   = sreg;
    if (accept) begin
      frame2_n = 1'b0;
      sreg_n   = wr_data;
    end else if (repeat_frame) begin
      frame2_n = 1'b1;
      sreg_n   = word_q;
    end else if (shift_step) begin
      sreg_n = {sreg[WIDTH-2:0], 1'b0};
    end
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    busy_d    = (state_n != S_IDLE);
    done_d    = end_tx;
    sync_n_d  = !(state_n inside {S_SETUP, S_SHIFT, S_HOLD});
    sclk_d    = !((state_n == S_SHIFT) && (cnt_n >= PH_FALL));
    din_d     = sync_n_d ? 1'b0 : sreg_n[WIDTH-1];
    cmp_en_d  = (state_n == S_SHIFT) && (cnt_n == PH_FALL) && frame2_n;
    cmp_clr_d = (state_n == S_SETUP) && (cnt_n == '0) && frame2_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      word_q     <= '0;
      verify_q   <= 1'b0;
      frame2     <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      cmp_en     <= 1'b0;
      cmp_clr    <= 1'b0;
    end else begin
      sreg   <= sreg_n;
      frame2 <= frame2_n;
      if (accept) begin
        word_q   <= wr_data;
        verify_q <= verify;
      end
      // Readback is taken at the end of the cycle in which SCLK is first low.
      if ((state == S_SHIFT) && (cnt == PH_FALL))
        rd_data <= {rd_data[WIDTH-2:0], dac_dout};
      busy       <= busy_d;
      done       <= done_d;
      dac_sclk   <= sclk_d;
      dac_sync_n <= sync_n_d;
      dac_din    <= din_d;
      cmp_en     <= cmp_en_d;
      cmp_clr    <= cmp_clr_d;
    end
  end

endmodule

// File: tb/tb_dac_serial_writer.sv
// Directed bench for dac_serial_writer: default instance with a daisy-chain model, plus a
// CLK_DIV=1 / WIDTH=8 instance with its readback looped to its data output.
module tb_dac_serial_writer;

  logic        clk, reset;
  logic        start, verify, busy, done;
  logic [23:0] wr_data, rd_data;
  logic        dac_sclk, dac_sync_n, dac_din, dac_dout, cmp_en, cmp_clr;
  logic [2:0]  fsm_state;

  logic        start2, verify2, busy2, done2;
  logic [7:0]  wr_data2, rd_data2;
  logic        sclk2, sync2_n, din2, dout2, cmp_en2, cmp_clr2;
  logic [2:0]  fsm_state2;

  int n_assert = 0;
  int n_fail   = 0;

  dac_serial_writer dut (
    .clk(clk), .reset(reset), .start(start), .wr_data(wr_data), .verify(verify),
    .busy(busy), .done(done), .rd_data(rd_data), .dac_sclk(dac_sclk),
    .dac_sync_n(dac_sync_n), .dac_din(dac_din), .dac_dout(dac_dout),
    .cmp_en(cmp_en), .cmp_clr(cmp_clr), .fsm_state(fsm_state)
  );

  dac_serial_writer #(.WIDTH(8), .CLK_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .wr_data(wr_data2), .verify(verify2),
    .busy(busy2), .done(done2), .rd_data(rd_data2), .dac_sclk(sclk2),
    .dac_sync_n(sync2_n), .dac_din(din2), .dac_dout(dout2),
    .cmp_en(cmp_en2), .cmp_clr(cmp_clr2), .fsm_state(fsm_state2)
  );

  assign dout2 = din2;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Daisy-chain model: DAC samples DIN on SCLK fall and advances its SDO on the next rise.
  logic [23:0] chain, chain_init;
  logic        cap, chain_load, inject;
  int          fall_cnt;

  always @(negedge dac_sclk or posedge chain_load)
    if (chain_load) begin
      cap      <= 1'b0;
      fall_cnt <= 0;
    end else begin
      cap      <= dac_din;
      fall_cnt <= fall_cnt + 1;
    end

  always @(posedge dac_sclk or posedge chain_load)
    if (chain_load) chain <= chain_init;
    else chain <= {chain[22:0], cap};

  // Fall 43 is frame-2 bit 18, which carries word bit 5.
  assign dac_dout = chain[23] ^ (inject && (fall_cnt == 43));

  // scoreboard
  int          st_busy, st_falls, st_en, st_mism, st_align, st_clr, st_clr_at, cyc;
  logic [23:0] st_din;
  logic        got_done, prev_sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic load_chain(input logic [23:0] init, input logic inj);
    chain_init = init;
    inject     = inj;
    chain_load = 1'b1;
    #1 chain_load = 1'b0;
  endtask

  task automatic kick(input logic [23:0] d, input logic v);
    wr_data = d;
    verify  = v;
    start   = 1'b1;
  endtask

  task automatic watch(input string name, input int budget, input bit expect_done,
                       input int poke_at, input bit b2b, input logic [23:0] next_data);
    @(negedge clk);
    start = 1'b0;
    st_busy = 0; st_falls = 0; st_en = 0; st_mism = 0; st_align = 0;
    st_clr = 0; st_clr_at = -1; st_din = '0; got_done = 1'b0; prev_sclk = 1'b1; cyc = 0;
    check({name, ":accept_busy"}, busy, 1);
    check({name, ":accept_sync_n"}, dac_sync_n, 0);
    while (cyc < budget) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) st_busy++;
      if (prev_sclk && !dac_sclk) begin
        st_falls++;
        st_din = {st_din[22:0], dac_din};
      end
      if (cmp_en) begin
        st_en++;
        if (dac_din !== dac_dout) st_mism++;
        if (!(prev_sclk && !dac_sclk)) st_align++;
      end
      if (cmp_clr) begin
        st_clr++;
        st_clr_at = cyc;
      end
      prev_sclk = dac_sclk;
      if (cyc == poke_at) begin
        start   = 1'b1;
        wr_data = 24'h0F0F0F;
        verify  = 1'b1;
      end else if (cyc == poke_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (expect_done) check({name, ":done_seen"}, got_done, 1);
    else check({name, ":no_done"}, got_done, 0);
    if (got_done) begin
      check({name, ":busy_low_at_done"}, busy, 0);
      if (b2b) begin
        kick(next_data, 1'b0);
      end else begin
        @(negedge clk);
        check({name, ":done_one_cycle"}, done, 0);
      end
    end
  endtask

  int          c2, b2, f2, first2, last2, en2;
  logic        prev2, got2;
  logic [7:0]  seq2;

  initial begin
    reset = 1'b1; start = 1'b0; verify = 1'b0; wr_data = '0;
    start2 = 1'b0; verify2 = 1'b0; wr_data2 = '0;
    chain_load = 1'b0; inject = 1'b0; chain_init = '0;
    load_chain(24'h123456, 1'b0);
    repeat (3) @(negedge clk);

    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:rd_data", rd_data, 0);
    check("rst:sclk", dac_sclk, 1);
    check("rst:sync_n", dac_sync_n, 1);
    check("rst:din", dac_din, 0);
    check("rst:cmp_en", cmp_en, 0);
    check("rst:cmp_clr", cmp_clr, 0);
    check("rst:state", fsm_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset while SHIFT is in bit counter 10 with SCLK low.
    kick(24'hA5C3F0, 1'b0);
    watch("midrst", 56, 1'b0, -1, 1'b0, '0);
    check("midrst:sclk_before", dac_sclk, 0);
    reset = 1'b1;
    #1;
    check("midrst:sclk", dac_sclk, 1);
    check("midrst:sync_n", dac_sync_n, 1);
    check("midrst:busy", busy, 0);
    check("midrst:din", dac_din, 0);
    check("midrst:rd_data", rd_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst:no_done", done, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    kick(24'h000001, 1'b0);
    watch("after_rst", 300, 1'b1, -1, 1'b0, '0);
    check("after_rst:busy_cycles", st_busy, 104);
    check("after_rst:din_word", st_din, 24'h000001);

    // Plain write; first frame reads back the chain's old contents.
    load_chain(24'h123456, 1'b0);
    kick(24'hA5C3F0, 1'b0);
    watch("plain", 300, 1'b1, -1, 1'b0, '0);
    check("plain:busy_cycles", st_busy, 104);
    check("plain:falls", st_falls, 24);
    check("plain:din_word", st_din, 24'hA5C3F0);
    check("plain:cmp_en_count", st_en, 0);
    check("plain:cmp_clr_count", st_clr, 0);
    check("plain:rd_data", rd_data, 24'h123456);

    // Verify write, clean chain.
    load_chain(24'h123456, 1'b0);
    kick(24'hA5C3F0, 1'b1);
    watch("verify", 500, 1'b1, -1, 1'b0, '0);
    check("verify:busy_cycles", st_busy, 208);
    check("verify:falls", st_falls, 48);
    check("verify:cmp_clr_count", st_clr, 1);
    check("verify:cmp_clr_at", st_clr_at, 104);
    check("verify:cmp_en_count", st_en, 24);
    check("verify:cmp_en_align", st_align, 0);
    check("verify:mismatches", st_mism, 0);
    check("verify:rd_data", rd_data, 24'hA5C3F0);

    // Verify write, chain corrupts word bit 5 in frame 2.
    load_chain(24'h123456, 1'b1);
    kick(24'hA5C3F0, 1'b1);
    watch("fault", 500, 1'b1, -1, 1'b0, '0);
    check("fault:cmp_en_count", st_en, 24);
    check("fault:mismatches", st_mism, 1);
    check("fault:rd_data", rd_data, 24'hA5C3D0);
    inject = 1'b0;

    // Start while busy is ignored; start in the done cycle chains a new transaction.
    kick(24'h3C3C3C, 1'b0);
    watch("poke", 300, 1'b1, 30, 1'b1, 24'h5A5A5A);
    check("poke:busy_cycles", st_busy, 104);
    check("poke:din_word", st_din, 24'h3C3C3C);
    check("poke:cmp_en_count", st_en, 0);
    watch("b2b", 300, 1'b1, -1, 1'b0, '0);
    check("b2b:busy_cycles", st_busy, 104);
    check("b2b:din_word", st_din, 24'h5A5A5A);

    // CLK_DIV=1, WIDTH=8 instance.
    start2 = 1'b1; wr_data2 = 8'h81; verify2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    c2 = 0; b2 = 0; f2 = 0; first2 = -1; last2 = -1; en2 = 0; seq2 = '0;
    prev2 = 1'b1; got2 = 1'b0;
    while (c2 < 60) begin
      if (done2) begin
        got2 = 1'b1;
        break;
      end
      if (busy2) b2++;
      if (prev2 && !sclk2) begin
        f2++;
        seq2 = {seq2[6:0], din2};
        if (first2 < 0) first2 = c2;
        last2 = c2;
      end
      if (cmp_en2) en2++;
      prev2 = sclk2;
      @(negedge clk);
      c2++;
    end
    check("div1:done_seen", got2, 1);
    check("div1:busy_cycles", b2, 20);
    check("div1:falls", f2, 8);
    check("div1:din_seq", seq2, 8'h81);
    check("div1:first_fall", first2, 2);
    check("div1:fall_span", last2 - first2, 14);
    check("div1:cmp_en_count", en2, 0);
    check("div1:rd_data", rd_data2, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_serial_writer.md
# dac_serial_writer

Serial transmitter for the front-end DAC daisy chain. It loads a parallel word, shifts it MSB-first on `dac_din` with a divided `dac_sclk` framed by `dac_sync_n`, and, in verify mode, sends the same word a second time while sampling `dac_dout`. During that second frame it drives the compare-enable and clear strobes consumed by the chain error detector (`enable`/`sclr` inputs there). In the second frame `dac_dout` bit-aligns with `dac_din`, so any mismatch flags a chain fault.

## Interface
- `WIDTH`, 24: bits per frame; ≥ 2.
- `CLK_DIV`, 2: `clk` cycles per SCLK phase; ≥ 1; one bit period = 2·CLK_DIV cycles.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `wr_data`  in  WIDTH  word to send; captured on accepted `start`.
- `verify`  in  1  captured with `start`; 1 = send the frame twice and compare.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at end of transaction.
- `rd_data`  out  WIDTH  bits sampled from `dac_dout` in the last frame, MSB first.
- `dac_sclk`  out  1  serial clock, idle high.
- `dac_sync_n`  out  1  frame select, active low, idle high.
- `dac_din`  out  1  serial data to DAC chain.
- `dac_dout`  in  1  daisy-chain readback.
- `cmp_en`  out  1  compare strobe to error detector.
- `cmp_clr`  out  1  clear strobe to error detector.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → GAP → (if verify and frame 1) SETUP … → IDLE.
- IDLE: on `start`=1 with `busy`=0, latch `wr_data` into the shift register, latch `verify`, clear the frame flag and go to SETUP. `start` is ignored while `busy`=1.
- SETUP (CLK_DIV cycles): `dac_sync_n`=0, `dac_sclk`=1, `dac_din`=MSB.
- SHIFT (WIDTH·2·CLK_DIV cycles), phase counter 0..2·CLK_DIV−1 per bit:
  - Phases 0..CLK_DIV−1: `dac_sclk`=1.
  - Phases CLK_DIV..end: `dac_sclk`=0.
  - `dac_din` changes only at phase 0.
  - At phase CLK_DIV (SCLK falling), shift `dac_dout` into the LSB of the `rd_data` register (shift left).
  - Bit counter counts WIDTH−1 down to 0.
- HOLD (CLK_DIV cycles): `dac_sclk`=1, `dac_sync_n`=0.
- GAP (2·CLK_DIV cycles): `dac_sync_n`=1, `dac_din`=0. Then:
  - If verify is set and frame 1 just ended: reload the latched word, set the frame flag, go to SETUP.
  - Otherwise go to IDLE and pulse `done`.
- `cmp_clr`: 1 for exactly the first cycle of SETUP of frame 2 (verify only).
- `cmp_en`: 1 for exactly the cycles where phase==CLK_DIV in SHIFT of frame 2. It is never asserted in frame 1 or in non-verify transactions.
- `rd_data` is held stable outside SHIFT and is valid when `done`=1.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `rd_data`=0, `dac_sclk`=1, `dac_sync_n`=1, `dac_din`=0, `cmp_en`=0, `cmp_clr`=0. State = IDLE.
- `start` accepted at edge N → `busy`=1 and `dac_sync_n`=0 from edge N+1.
- Frame length F = CLK_DIV + 2·CLK_DIV·WIDTH + CLK_DIV + 2·CLK_DIV cycles (F=104 at defaults).
- `busy` is high for F cycles without verify, 2F with verify. `done` is high in the cycle after the last GAP cycle and `busy` falls in that same cycle.
- Earliest next `start` is accepted in the `done` cycle, which gives back-to-back transactions with a 1-cycle gap.
- `cmp_en` rises in the same cycle as `dac_sclk` falls. Exactly WIDTH `cmp_en` pulses occur per verify transaction.
- Reset asserted mid-transaction forces the reset values immediately. No `done` is produced. The next `start` after reset release is served normally.
- CLK_DIV=1: SETUP and HOLD are 1 cycle and SCLK toggles every cycle; the rules above still hold.

## Test plan
- Reset mid-SHIFT (bit 10): outputs take reset values asynchronously; no `done`; a following `start` with 0x000001 completes in 104 cycles.
- Defaults, `verify`=0, `wr_data`=0xA5C3F0: 24 SCLK falls; `dac_din` sampled at falls = 0xA5C3F0; `busy` high 104 cycles; `done` 1 cycle; `cmp_en` never 1.
- Verify=1 with a chain model delaying `dac_din` by WIDTH SCLK edges (initial contents 0x123456):
  - `cmp_clr` is 1 once, at frame-2 SETUP; 24 `cmp_en` pulses occur, with `dac_din`==`dac_dout` at each.
  - `rd_data`=0xA5C3F0 at `done`; `busy` is high 208 cycles.
- Same as above with the model inverting bit 5 in frame 2: `dac_din`≠`dac_dout` at exactly one `cmp_en` pulse; `rd_data`=0xA5C3D0.
- `start` pulsed while `busy`: ignored, with no change to the frame; `start` held high in the `done` cycle begins a new transaction on the next edge.
- CLK_DIV=1, WIDTH=8, `wr_data`=0x81: SCLK period 2 cycles, F=20; `dac_din` sequence 1,0,0,0,0,0,0,1.
